// File: rtl/scr1_dmi_ctrl_pkg.sv
// Shared DMI/DTM encodings for the debug transport chain.
// Contents: DMI op codes, JTAG chain ids for the DTM registers, dtmcs
// field positions, the DTM version, and a helper that packs a dtmcs word.
package scr1_dmi_ctrl_pkg;

  // DMI op field: request codes on update, status codes on capture
  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [1:0] DMI_OP_BUSY  = 2'd3;
  localparam logic [1:0] DMI_STAT_OK   = 2'd0;
  localparam logic [1:0] DMI_STAT_BUSY = 2'd3;

  // TAP chain ids routed to this block
  localparam int DTM_CH_ID_DTMCS = 1;
  localparam int DTM_CH_ID_DMI   = 2;

  // dtmcs bit positions
  localparam int DTMCS_VERSION_LO  = 0;
  localparam int DTMCS_ABITS_LO    = 4;
  localparam int DTMCS_DMISTAT_LO  = 10;
  localparam int DTMCS_IDLE_LO     = 12;
  localparam int DTMCS_DMIRESET    = 16;
  localparam int DTMCS_DMIHARDRST  = 17;

  localparam logic [3:0] DTM_VERSION = 4'd1;

  // dtmcs as seen on capture; the reset request bits always read as 0
  function automatic logic [31:0] dtmcs_word(input logic [2:0] idle,
                                             input logic [1:0] stat,
                                             input logic [5:0] abits);
    dtmcs_word = {14'b0, 1'b0, 1'b0, 1'b0, idle, stat, abits, DTM_VERSION};
  endfunction

endpackage

// File: rtl/scr1_dmi_ctrl.sv
// Debug Module Interface controller between the TAP chain interface and the DM.
// Holds each DMI request until the DM answers (arbitrary latency), keeps a
// sticky busy status, and implements dtmcs dmireset/dmihardreset.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   dtm_ch_sel/id            - chain select and chain id (1=dtmcs, 2=dmi)
//   dtm_ch_capture/shift/update, dtm_ch_tdi, dtm_ch_tdo - DR strobes and serial data
//   dmi_req/wr/addr/wdata    - request to DM, held until dmi_resp
//   dmi_resp/rdata           - DM completion and read data
module scr1_dmi_ctrl
  import scr1_dmi_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 32,
  parameter int IDLE_HINT   = 0,
  parameter int CH_ID_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dtm_ch_sel,
  input  logic [CH_ID_WIDTH-1:0] dtm_ch_id,
  input  logic                   dtm_ch_capture,
  input  logic                   dtm_ch_shift,
  input  logic                   dtm_ch_update,
  input  logic                   dtm_ch_tdi,
  output logic                   dtm_ch_tdo,
  input  logic                   dmi_resp,
  input  logic [DATA_WIDTH-1:0]  dmi_rdata,
  output logic                   dmi_req,
  output logic                   dmi_wr,
  output logic [ADDR_WIDTH-1:0]  dmi_addr,
  output logic [DATA_WIDTH-1:0]  dmi_wdata
);

  localparam int DMI_W = ADDR_WIDTH + DATA_WIDTH + 2;
  // The DR must also hold the 32-bit dtmcs view when the DMI view is narrower
  localparam int DR_W  = (DMI_W > 32) ? DMI_W : 32;

  localparam logic [CH_ID_WIDTH-1:0] ID_DTMCS = CH_ID_WIDTH'(DTM_CH_ID_DTMCS);
  localparam logic [CH_ID_WIDTH-1:0] ID_DMI   = CH_ID_WIDTH'(DTM_CH_ID_DMI);
  localparam logic [2:0]             IDLE_VAL = 3'(IDLE_HINT);
  localparam logic [5:0]             ABITS    = 6'(ADDR_WIDTH);

  typedef enum logic {ST_IDLE, ST_REQ} state_e;

  state_e                state_q, state_d;
  logic [DR_W-1:0]       dr_q, dr_d;
  logic [1:0]            sticky_q, sticky_d;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Qualified strobes: capture beats shift, update never overlaps either
  logic cap, sh, upd;
  logic is_dtmcs, is_dmi;
  assign cap      = dtm_ch_sel & dtm_ch_capture;
  assign sh       = dtm_ch_sel & dtm_ch_shift & ~dtm_ch_capture;
  assign upd      = dtm_ch_sel & dtm_ch_update;
  assign is_dtmcs = (dtm_ch_id == ID_DTMCS);
  assign is_dmi   = (dtm_ch_id == ID_DMI);

  // DMI fields of the DR as left by the last shift
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic [DATA_WIDTH-1:0] upd_data;
  logic [1:0]            upd_op;
  assign upd_addr = dr_q[DMI_W-1 -: ADDR_WIDTH];
  assign upd_data = dr_q[DATA_WIDTH+1:2];
  assign upd_op   = dr_q[1:0];

  logic in_req;
  logic hardreset, dmireset;
  logic busy_cap, busy_upd;
  logic dmi_start, dmi_done;
  logic [1:0] cap_op;

  assign in_req    = (state_q == ST_REQ);
  assign hardreset = upd & is_dtmcs & dr_q[DTMCS_DMIHARDRST];
  assign dmireset  = upd & is_dtmcs & dr_q[DTMCS_DMIRESET];
  // Touching the DMI register while a request is in flight marks the chain busy
  assign busy_cap  = cap & is_dmi & in_req;
  assign busy_upd  = upd & is_dmi & in_req;
  assign dmi_start = upd & is_dmi & ~in_req & (sticky_q == DMI_STAT_OK)
                   & ((upd_op == DMI_OP_READ) | (upd_op == DMI_OP_WRITE));
  // A hardreset in the same cycle abandons the response
  assign dmi_done  = in_req & dmi_resp & ~hardreset;
  assign cap_op    = in_req ? DMI_OP_BUSY : sticky_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dmi_start) state_d = ST_REQ;
      ST_REQ:  if (hardreset || dmi_resp) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky status: either reset bit clears it, busy events set it
  always_comb begin
    sticky_d = sticky_q;
    if (hardreset || dmireset)  sticky_d = DMI_STAT_OK;
    else if (busy_cap || busy_upd) sticky_d = DMI_STAT_BUSY;
  end

  // DR next value; each chain id has its own view width
  always_comb begin
    dr_d = dr_q;
    if (cap) begin
      dr_d = '0;
      if (is_dtmcs)    dr_d[31:0]      = dtmcs_word(IDLE_VAL, sticky_q, ABITS);
      else if (is_dmi) dr_d[DMI_W-1:0] = {last_addr_q, rdata_q, cap_op};
    end else if (sh) begin
      if (is_dtmcs)    dr_d[31:0]      = {dtm_ch_tdi, dr_q[31:1]};
      else if (is_dmi) dr_d[DMI_W-1:0] = {dtm_ch_tdi, dr_q[DMI_W-1:1]};
      else             dr_d[0]         = dtm_ch_tdi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dr_q        <= '0;
      sticky_q    <= DMI_STAT_OK;
      last_addr_q <= '0;
      rdata_q     <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      dr_q     <= dr_d;
      sticky_q <= sticky_d;
      // Request fields only load from IDLE, so they hold steady during REQ
      if (dmi_start) begin
        addr_q      <= upd_addr;
        wdata_q     <= upd_data;
        wr_q        <= (upd_op == DMI_OP_WRITE);
        last_addr_q <= upd_addr;
      end
      if (dmi_done && !wr_q) rdata_q <= dmi_rdata;
    end
  end

  assign dmi_req    = in_req;
  assign dmi_wr     = wr_q;
  assign dmi_addr   = addr_q;
  assign dmi_wdata  = wdata_q;
  assign dtm_ch_tdo = dr_q[0];

endmodule

// File: tb/tb_scr1_dmi_ctrl.sv
// Directed bench for scr1_dmi_ctrl: JTAG-style DR scans drive DMI
// reads/writes, busy handling, dmireset/dmihardreset and reset mid-request.
// A second instance with ADDR_WIDTH=9, IDLE_HINT=5 checks the dtmcs word.
module tb_scr1_dmi_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        dtm_ch_sel, dtm_ch_capture, dtm_ch_shift, dtm_ch_update, dtm_ch_tdi;
  logic [1:0]  dtm_ch_id;
  logic        dtm_ch_tdo, tdo9;
  logic        dmi_resp;
  logic [31:0] dmi_rdata;
  logic        dmi_req, dmi_wr;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic        req9, wr9;
  logic [8:0]  addr9;
  logic [31:0] wdata9;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scr1_dmi_ctrl dut (
    .clk(clk), .rst(rst), .dtm_ch_sel(dtm_ch_sel), .dtm_ch_id(dtm_ch_id),
    .dtm_ch_capture(dtm_ch_capture), .dtm_ch_shift(dtm_ch_shift),
    .dtm_ch_update(dtm_ch_update), .dtm_ch_tdi(dtm_ch_tdi), .dtm_ch_tdo(dtm_ch_tdo),
    .dmi_resp(dmi_resp), .dmi_rdata(dmi_rdata), .dmi_req(dmi_req), .dmi_wr(dmi_wr),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata)
  );

  scr1_dmi_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .IDLE_HINT(5), .CH_ID_WIDTH(2)) dut9 (
    .clk(clk), .rst(rst), .dtm_ch_sel(dtm_ch_sel), .dtm_ch_id(dtm_ch_id),
    .dtm_ch_capture(dtm_ch_capture), .dtm_ch_shift(dtm_ch_shift),
    .dtm_ch_update(dtm_ch_update), .dtm_ch_tdi(dtm_ch_tdi), .dtm_ch_tdo(tdo9),
    .dmi_resp(1'b0), .dmi_rdata(32'h0), .dmi_req(req9), .dmi_wr(wr9),
    .dmi_addr(addr9), .dmi_wdata(wdata9)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d,
                                      input logic [1:0] op);
    dmi = {23'b0, a, d, op};
  endfunction

  // capture, shift len bits (collecting tdo), update
  task automatic scan(input logic [1:0] id, input logic [63:0] din, input int len,
                      output logic [63:0] dout, output logic [31:0] dout9);
    dout  = '0;
    dout9 = '0;
    dtm_ch_sel = 1'b1; dtm_ch_id = id; dtm_ch_capture = 1'b1;
    tick();
    dtm_ch_capture = 1'b0;
    for (int i = 0; i < len; i++) begin
      dtm_ch_shift = 1'b1;
      dtm_ch_tdi   = din[i];
      dout[i]      = dtm_ch_tdo;
      if (i < 32) dout9[i] = tdo9;
      tick();
    end
    dtm_ch_shift = 1'b0; dtm_ch_tdi = 1'b0; dtm_ch_update = 1'b1;
    tick();
    dtm_ch_update = 1'b0; dtm_ch_sel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] o;
    logic [31:0] o9;
    rst = 1'b1; dtm_ch_sel = 0; dtm_ch_id = 0; dtm_ch_capture = 0; dtm_ch_shift = 0;
    dtm_ch_update = 0; dtm_ch_tdi = 0; dmi_resp = 0; dmi_rdata = 0;
    tick(); tick();
    chk("rst_req",   dmi_req,   0);
    chk("rst_wr",    dmi_wr,    0);
    chk("rst_addr",  dmi_addr,  0);
    chk("rst_wdata", dmi_wdata, 0);
    chk("rst_tdo",   dtm_ch_tdo, 0);
    rst = 1'b0;
    tick();

    // dtmcs word for both parameterisations
    scan(2'd1, 64'h0, 32, o, o9);
    chk("dtmcs_a7",  o,  64'h71);
    chk("dtmcs_a9",  o9, 32'h5091);

    // Read with 3-cycle DM latency
    scan(2'd2, dmi(7'h11, 32'h0, 2'd1), 41, o, o9);
    chk("rd_cap0", o, 64'h0);
    chk("rd_req1", dmi_req, 1);
    chk("rd_addr", dmi_addr, 7'h11);
    chk("rd_wr",   dmi_wr, 0);
    tick();
    chk("rd_req2", dmi_req, 1);
    tick();
    chk("rd_req3", dmi_req, 1);
    dmi_resp = 1; dmi_rdata = 32'hDEADBEEF;
    tick();
    dmi_resp = 0; dmi_rdata = 0;
    chk("rd_done", dmi_req, 0);
    scan(2'd2, 64'h0, 41, o, o9);
    chk("rd_data", o, dmi(7'h11, 32'hDEADBEEF, 2'd0));
    chk("nop_noreq", dmi_req, 0);

    // Write
    scan(2'd2, dmi(7'h04, 32'h1, 2'd2), 41, o, o9);
    chk("wr_req",   dmi_req, 1);
    chk("wr_wr",    dmi_wr, 1);
    chk("wr_addr",  dmi_addr, 7'h04);
    chk("wr_wdata", dmi_wdata, 32'h1);
    tick();
    chk("wr_hold",  {dmi_req, dmi_wr, dmi_wdata}, {2'b11, 32'h1});
    dmi_resp = 1; dmi_rdata = 32'h12345678;
    tick();
    dmi_resp = 0; dmi_rdata = 0;
    chk("wr_done", dmi_req, 0);
    scan(2'd2, 64'h0, 41, o, o9);
    chk("wr_keep_rdata", o, dmi(7'h04, 32'hDEADBEEF, 2'd0));

    // Busy: second op while the DM stalls
    scan(2'd2, dmi(7'h22, 32'h0, 2'd1), 41, o, o9);
    chk("busy_req", dmi_req, 1);
    scan(2'd2, dmi(7'h33, 32'h0, 2'd1), 41, o, o9);
    chk("busy_cap", o, dmi(7'h22, 32'hDEADBEEF, 2'd3));
    chk("busy_noreq2", dmi_addr, 7'h22);
    dmi_resp = 1; dmi_rdata = 32'hA5A5A5A5;
    tick();
    dmi_resp = 0; dmi_rdata = 0;
    chk("busy_done", dmi_req, 0);
    scan(2'd1, 64'h0, 32, o, o9);
    chk("busy_dmistat", o, 64'hC71);
    scan(2'd2, dmi(7'h55, 32'h0, 2'd1), 41, o, o9);
    chk("sticky_cap", o, dmi(7'h22, 32'hA5A5A5A5, 2'd3));
    chk("sticky_noreq", dmi_req, 0);
    scan(2'd1, 64'h1 << 16, 32, o, o9);
    chk("dmireset_cap", o, 64'hC71);
    scan(2'd1, 64'h0, 32, o, o9);
    chk("dmireset_clr", o, 64'h71);
    scan(2'd2, dmi(7'h66, 32'h0, 2'd1), 41, o, o9);
    chk("after_clr_cap", o, dmi(7'h22, 32'hA5A5A5A5, 2'd0));
    chk("after_clr_req", {dmi_req, dmi_addr}, {1'b1, 7'h66});
    dmi_resp = 1; dmi_rdata = 32'h0BADF00D;
    tick();
    dmi_resp = 0; dmi_rdata = 0;

    // Hardreset abandons the outstanding read
    scan(2'd2, dmi(7'h77, 32'h0, 2'd1), 41, o, o9);
    chk("hr_req", dmi_req, 1);
    scan(2'd1, 64'h1 << 17, 32, o, o9);
    chk("hr_cap", o, 64'h71);
    chk("hr_drop", dmi_req, 0);
    dmi_resp = 1; dmi_rdata = 32'h0000CAFE;
    tick();
    dmi_resp = 0; dmi_rdata = 0;
    chk("hr_late", dmi_req, 0);
    scan(2'd2, 64'h0, 41, o, o9);
    chk("hr_rdata", o, dmi(7'h77, 32'h0BADF00D, 2'd0));

    // Reset mid-request
    scan(2'd2, dmi(7'h12, 32'h89ABCDEF, 2'd2), 41, o, o9);
    chk("mid_req", {dmi_req, dmi_wr, dmi_wdata}, {2'b11, 32'h89ABCDEF});
    rst = 1'b1;
    tick();
    chk("mid_rst_out", {dmi_req, dmi_wr, dmi_addr, dmi_wdata, dtm_ch_tdo}, 64'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_idle", dmi_req, 0);
    scan(2'd1, 64'h0, 32, o, o9);
    chk("mid_rst_stat", o, 64'h71);
    scan(2'd2, 64'h0, 41, o, o9);
    chk("mid_rst_dr", o, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/scr1_dmi_ctrl.md
Name: scr1_dmi_ctrl

Overview:
Parametrised Debug Module Interface controller between the TAP/DTM chain interface and the Debug Module (DM). It replaces the fire-and-forget single-cycle DMI with a held request/response handshake of arbitrary latency and a sticky busy status. It also handles dtmcs dmireset/dmihardreset and uses configurable address and data widths. It sits between the TAP controller and scr1_dm.

Parameters:
ADDR_WIDTH, 7, DMI address width; reported in dtmcs.abits (must be 1..63).
DATA_WIDTH, 32, DMI data width.
IDLE_HINT, 0, value reported in dtmcs.idle (3 bits).
CH_ID_WIDTH, 2, width of dtm_ch_id.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
dtm_ch_sel  in  1  this chain selected
dtm_ch_id  in  CH_ID_WIDTH  1=DTMCS, 2=DMI, other=unused
dtm_ch_capture  in  1  capture-DR strobe
dtm_ch_shift  in  1  shift-DR strobe
dtm_ch_update  in  1  update-DR strobe
dtm_ch_tdi  in  1  serial in
dtm_ch_tdo  out  1  serial out = DR bit 0
dmi_resp  in  1  DM accepts/completes the current request
dmi_rdata  in  DATA_WIDTH  DM read data, valid with dmi_resp
dmi_req  out  1  request, held until dmi_resp
dmi_wr  out  1  1=write, 0=read
dmi_addr  out  ADDR_WIDTH  request address
dmi_wdata  out  DATA_WIDTH  request write data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst). Every register, including the DR and the FSM, is updated only on posedge clk.
- Reset values: dmi_req=0, dmi_wr=0, dmi_addr=0, dmi_wdata=0, DR=0 (so tdo=0), rdata_ff=0, last_addr=0, sticky=0, FSM=IDLE.
- DR width: DMI_W = ADDR_WIDTH+DATA_WIDTH+2. The DTMCS view uses the low 32 bits.
- Strobes act only when dtm_ch_sel=1. capture has priority over shift; update is exclusive with both.
- Capture, id 1 (DTMCS): {14'b0, hardreset=0, reset=0, 1'b0, IDLE_HINT[2:0], dmistat=sticky, abits=ADDR_WIDTH[5:0], version=4'd1}.
- Capture, id 2 (DMI): {last_addr, rdata_ff, op}.
  - op = 2'd3 if FSM=REQ; this also sets sticky=3.
  - otherwise op = sticky.
- Capture, other id: DR=0.
- Shift: tdi enters at the MSB of the active view (bit 31 for DTMCS, DMI_W-1 for DMI, bit 0 for other ids). The view shifts right by one.
- Update, id 1:
  - DR bit 16 = 1 -> sticky=0.
  - DR bit 17 = 1 -> sticky=0, FSM=IDLE, dmi_req=0 on the next cycle. The outstanding response is abandoned and any dmi_resp arriving after the abort is ignored.
- Update, id 2, with op = DR[1:0]:
  - FSM=REQ -> no request; sticky=3.
  - sticky != 0 -> no request.
  - op=1 (read) or op=2 (write) -> latch dmi_addr=DR addr field, dmi_wdata=DR data field, dmi_wr=(op==2), last_addr=addr. FSM -> REQ, and dmi_req=1 from the next cycle.
  - op=0 or op=3 -> no request.
- FSM IDLE/REQ:
  - In REQ, dmi_req=1 and dmi_addr/dmi_wr/dmi_wdata stay stable.
  - A cycle with dmi_req & dmi_resp completes the request. For a read, rdata_ff=dmi_rdata in that cycle. FSM -> IDLE and dmi_req=0 on the next cycle.
  - Minimum request duration is 1 cycle. There is no timeout.
- Simultaneous events:
  - dmi_resp in the same cycle as a DMI capture -> capture reports op=3 and sets sticky (FSM still REQ that cycle); the data completes normally.
  - Hardreset in the same cycle as dmi_resp -> abort wins and rdata_ff is not updated.
  - rst overrides everything.
- Write responses never modify rdata_ff.

Decomposition:
- Add to scr1_dm.svh:
  - DMI op encodings (NOP=0, READ=1, WRITE=2, BUSY/STAT_BUSY=3).
  - Channel IDs (DTMCS=1, DMI=2).
  - DTMCS bit-position localparams.
  - DTM version constant.
- FSM state typedef (IDLE, REQ): local to the module.
- No sub-module; the DR shift register and the FSM are kept in one module.

Test Plan:
- Read, 3-cycle DM latency: update DMI {addr=7'h11, op=1}. Expect dmi_req=1 the next cycle, held 3 cycles, addr=7'h11, wr=0. DM returns 32'hDEADBEEF. The next DMI capture shifts out {7'h11, 32'hDEADBEEF, 2'b00}.
- Write: update {addr=7'h04, data=32'h1, op=2}. Expect dmi_req & dmi_wr=1, wdata=32'h1 stable until resp. rdata_ff is unchanged afterwards.
- Busy:
  - Update a second DMI op while the DM holds off resp -> no second request.
  - The next capture shows op=3 and DTMCS capture shows dmistat=3.
  - A further update with op=1 is ignored.
  - DTMCS update with bit16=1 -> dmistat=0, and a new read proceeds.
- Hardreset: request outstanding, DTMCS update with bit17=1 -> dmi_req=0 the next cycle. A late dmi_resp with 32'hCAFE leaves rdata_ff unchanged.
- DTMCS capture with ADDR_WIDTH=9, IDLE_HINT=5 -> 32'h0000_5091.
- Reset mid-request: assert rst with dmi_req=1 -> the next cycle shows all outputs 0, tdo=0, FSM IDLE, sticky 0.
